// File: rtl/inst_boot_loader.sv
// -----------------------------------------------------------------------------
// inst_boot_loader
//
// Purpose:
//   Sits upstream of the instruction RAM write port. It receives a byte stream
//   from the UART receiver and assembles little-endian 32-bit words. Each word
//   is written to the RAM, and an additive 8-bit checksum is verified at the
//   end. The core is held in reset until a load completes cleanly.
//
//   Frame layout: 4 length bytes N (LE) | N*4 data bytes (LE per word) |
//                 1 checksum byte (sum of data bytes, mod 256).
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   start        1-cycle pulse that arms a new load (ignored while busy)
//   rx_data      byte from the UART receiver
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte; transfer when rx_valid & rx_ready
//   is_write     instruction RAM write strobe, one cycle per word
//   im_addr      byte address of the write (word aligned)
//   im_inst      word to write
//   busy         load in progress (LEN, DATA, CSUM)
//   load_done    load finished and checksum matched
//   load_err     bad length or checksum mismatch
//   core_rst_n   core reset release, high only in DONE
//   word_cnt     words written so far in the current load
// -----------------------------------------------------------------------------
module inst_boot_loader #(
  parameter int W         = 32,
  parameter int DEPTH     = 2048,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         is_write,
  output logic [W-1:0] im_addr,
  output logic [W-1:0] im_inst,
  output logic         busy,
  output logic         load_done,
  output logic         load_err,
  output logic         core_rst_n,
  output logic [W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t       state_q,    state_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [31:0]  len_q,      len_d;
  logic [31:0]  word_q,     word_d;
  logic [7:0]   sum_q,      sum_d;
  logic [W-1:0] word_cnt_q, word_cnt_d;
  logic [W-1:0] im_addr_q,  im_addr_d;
  logic [W-1:0] im_inst_q,  im_inst_d;
  logic         is_write_q, is_write_d;
  logic         rx_ready_q, rx_ready_d;

  logic         accept;
  logic [31:0]  len_full;
  logic [31:0]  word_full;
  logic [4:0]   bit_base;

  assign accept    = rx_valid & rx_ready_q;
  assign bit_base  = {byte_idx_q, 3'b000};
  // The 4th byte completes the value in the same cycle it arrives, so the
  // length check and the write both see the full value without waiting.
  assign len_full  = {rx_data, len_q[23:0]};
  assign word_full = {rx_data, word_q[23:0]};

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    word_d     = word_q;
    sum_d      = sum_q;
    word_cnt_d = word_cnt_q;
    im_addr_d  = im_addr_q;
    im_inst_d  = im_inst_q;
    is_write_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_idx_d = 2'd0;
          len_d      = '0;
          sum_d      = '0;
          word_cnt_d = '0;
        end
      end

      S_LEN: begin
        if (accept) begin
          len_d[bit_base +: 8] = rx_data;
          byte_idx_d           = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (len_full >= 32'd1 && len_full <= 32'(DEPTH)) state_d = S_DATA;
            else                                             state_d = S_ERR;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d[bit_base +: 8] = rx_data;
          sum_d                 = sum_q + rx_data;
          byte_idx_d            = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Write strobe, address, data and count all become visible
            // together in the cycle after the last byte of the word.
            is_write_d = 1'b1;
            im_addr_d  = W'(BASE_ADDR) + (word_cnt_q << 2);
            im_inst_d  = W'(word_full);
            word_cnt_d = word_cnt_q + W'(1);
            if ((word_cnt_q + W'(1)) == W'(len_q)) state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          if (rx_data == sum_q) state_d = S_DONE;
          else                  state_d = S_ERR;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so it is already valid in the first
    // cycle of each receiving state.
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      word_cnt_q <= '0;
      im_addr_q  <= '0;
      im_inst_q  <= '0;
      is_write_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      word_cnt_q <= word_cnt_d;
      im_addr_q  <= im_addr_d;
      im_inst_q  <= im_inst_d;
      is_write_q <= is_write_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // DONE and ERR are left only through start, so the sticky status flags are
  // simply decodes of the state register.
  assign rx_ready   = rx_ready_q;
  assign is_write   = is_write_q;
  assign im_addr    = im_addr_q;
  assign im_inst    = im_inst_q;
  assign word_cnt   = word_cnt_q;
  assign busy       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign load_done  = (state_q == S_DONE);
  assign load_err   = (state_q == S_ERR);
  assign core_rst_n = (state_q == S_DONE);

endmodule
